imm_load_ctrl: RTL and testbench

Sequencer for the immediate-extender datapath of the 16-bit core. It accepts loadlit/lcl/lch requests through a valid/ready handshake and drives the extender's control and constant inputs. It performs the register-file read-modify-write needed for the byte-insert forms, writes the result back, and reports completion or error.

---
 rtl/imm_load_ctrl.sv | 152 +++++++++++++++
 tb/tb_imm_load_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_load_ctrl.sv
// imm_load_ctrl
// Sequencer for the immediate extender of the 16-bit core. It accepts
// loadlit / lcl / lch requests through a valid/ready handshake and steps
// through the extender, performs the register-file read-modify-write that
// the byte-insert forms need, and writes the result back.
//
// Ports:
//   clock, reset_n              rising-edge clock, async active-low reset
//   req_valid/req_ready         request handshake (ready only while IDLE)
//   req_op/req_dest/req_const   op (00 loadlit, 01 lcl, 10 lch, 11 illegal),
//                               destination register, 11-bit immediate
//   ext_controle/ext_constante  extender control and constant inputs
//   ext_palavra                 extender result
//   rf_rd_addr/rf_rd_data       register-file read (data one cycle later)
//   rf_wr_en/addr/data          register-file write strobe
//   done/err                    completion / illegal-op pulses
//   busy                        high whenever not IDLE
//   op_count                    saturating count of completed legal ops
module imm_load_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [REG_ADDR_W-1:0] req_dest,
    input  logic [10:0]           req_const,
    output logic [1:0]            ext_controle,
    output logic [10:0]           ext_constante,
    input  logic [15:0]           ext_palavra,
    output logic [REG_ADDR_W-1:0] rf_rd_addr,
    input  logic [15:0]           rf_rd_data,
    output logic                  rf_wr_en,
    output logic [REG_ADDR_W-1:0] rf_wr_addr,
    output logic [15:0]           rf_wr_data,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXT   = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [1:0] OP_LOADLIT = 2'b00;
    localparam logic [1:0] OP_LCH     = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;
    // The extender only re-evaluates on a control change, so it is parked
    // at this value outside EXT to guarantee a transition per operation.
    localparam logic [1:0] CTL_PARK   = 2'b11;

    state_t                  state_reg, state_next;
    logic [1:0]              op_reg, op_next;
    logic [REG_ADDR_W-1:0]   dest_reg, dest_next;
    logic [10:0]             const_reg, const_next;
    logic [15:0]             merged_reg, merged_next;
    logic [CNT_W-1:0]        count_reg, count_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            op_reg     <= 2'b00;
            dest_reg   <= '0;
            const_reg  <= '0;
            merged_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            dest_reg   <= dest_next;
            const_reg  <= const_next;
            merged_reg <= merged_next;
            count_reg  <= count_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        dest_next     = dest_reg;
        const_next    = const_reg;
        merged_next   = merged_reg;
        count_next    = count_reg;
        req_ready     = 1'b0;
        ext_controle  = CTL_PARK;
        ext_constante = '0;
        rf_wr_en      = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        busy          = 1'b1;

        case (state_reg)
            IDLE: begin
                busy      = 1'b0;
                req_ready = 1'b1;
                if (req_valid) begin
                    op_next    = req_op;
                    dest_next  = req_dest;
                    const_next = req_const;
                    state_next = (req_op == OP_ILLEGAL) ? ERR : EXT;
                end
            end
            EXT: begin
                ext_controle = op_reg;
                case (op_reg)
                    OP_LOADLIT: ext_constante = const_reg;
                    OP_LCH:     ext_constante = {3'b000, const_reg[7:0]};
                    default:    ext_constante = '0;
                endcase
                state_next = MERGE;
            end
            MERGE: begin
                // rf_rd_data is the read issued in EXT; ext_palavra still
                // holds the result evaluated in EXT.
                case (op_reg)
                    OP_LOADLIT: merged_next = ext_palavra;
                    OP_LCH:     merged_next = {ext_palavra[15:8], rf_rd_data[7:0]};
                    default:    merged_next = {rf_rd_data[15:8], const_reg[7:0]};
                endcase
                state_next = WRITE;
            end
            WRITE: begin
                rf_wr_en = 1'b1;
                done     = 1'b1;
                if (count_reg != {CNT_W{1'b1}}) begin
                    count_next = count_reg + 1'b1;
                end
                state_next = IDLE;
            end
            ERR: begin
                err        = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rf_rd_addr = dest_reg;
    assign rf_wr_addr = dest_reg;
    assign rf_wr_data = merged_reg;
    assign op_count   = count_reg;

endmodule

// File: tb/tb_imm_load_ctrl.sv
// Directed bench for imm_load_ctrl with a behavioural extender and register
// file. Expected writes are queued when a request is issued and popped when
// the DUT strobes rf_wr_en. The counter width is reduced so saturation can
// be reached within a short run.
module tb_imm_load_ctrl;

    localparam int AW = 4;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [AW-1:0] req_dest = '0;
    logic [10:0]   req_const = '0;
    logic [1:0]    ext_controle;
    logic [10:0]   ext_constante;
    logic [15:0]   ext_palavra = 16'h0000;
    logic [AW-1:0] rf_rd_addr;
    logic [15:0]   rf_rd_data;
    logic          rf_wr_en;
    logic [AW-1:0] rf_wr_addr;
    logic [15:0]   rf_wr_data;
    logic          done, err, busy;
    logic [CW-1:0] op_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] rf [16];
    logic [15:0] gold [16];
    logic [19:0] sb_q [$];
    logic        pre_en = 1'b0;
    logic [3:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    always #5 clock = ~clock;

    imm_load_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_dest(req_dest), .req_const(req_const),
        .ext_controle(ext_controle), .ext_constante(ext_constante),
        .ext_palavra(ext_palavra),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .done(done), .err(err), .busy(busy), .op_count(op_count)
    );

    // Extender: evaluates only when driven with a non-park control and holds
    // its result otherwise. lcl yields a junk pattern the DUT must ignore.
    always @(ext_controle or ext_constante) begin
        if (ext_controle != 2'b11) begin
            case (ext_controle)
                2'b00:   ext_palavra = {{5{ext_constante[10]}}, ext_constante};
                2'b10:   ext_palavra = {ext_constante[7:0], 8'h00};
                default: ext_palavra = 16'hDEAD;
            endcase
        end
    end

    // Register file with registered read.
    always @(posedge clock) begin
        rf_rd_data <= rf[rf_rd_addr];
        if (pre_en) rf[pre_addr] <= pre_data;
        else if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        logic [19:0] e;
        @(posedge clock);
        #1;
        check("done_err_exclusive", {31'b0, done & err}, 32'd0);
        if (rf_wr_en) begin
            check("write_expected", {31'b0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("wr_addr", {28'b0, rf_wr_addr}, {28'b0, e[19:16]});
                check("wr_data", {16'b0, rf_wr_data}, {16'b0, e[15:0]});
                $display("write r%0d = %04h", rf_wr_addr, rf_wr_data);
            end
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clock);
        #1;
        pre_en = 1'b0;
        gold[a] = d;
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] dest, input logic [10:0] c);
        logic [15:0] d;
        req_valid = 1'b1; req_op = op; req_dest = dest; req_const = c;
        if (op != 2'b11) begin
            case (op)
                2'b00:   d = {{5{c[10]}}, c};
                2'b01:   d = {gold[dest][15:8], c[7:0]};
                default: d = {c[7:0], gold[dest][7:0]};
            endcase
            gold[dest] = d;
            sb_q.push_back({dest, d});
        end
        $display("issue op=%0d dest=r%0d const=%03h", op, dest, c);
    endtask

    task automatic run_legal(input logic [1:0] op, input logic [3:0] dest, input logic [10:0] c);
        issue(op, dest, c);
        tick();
        req_valid = 1'b0;
        check("ext_ctl_in_ext", {30'b0, ext_controle}, {30'b0, op});
        tick();
        tick();
        check("done_in_write", {31'b0, done}, 32'd1);
        tick();
        check("done_low_after", {31'b0, done}, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_ext_ctl", {30'b0, ext_controle}, 32'd3);
        check("rst_ext_const", {21'b0, ext_constante}, 32'd0);
        check("rst_rd_addr", {28'b0, rf_rd_addr}, 32'd0);
        check("rst_wr_en", {31'b0, rf_wr_en}, 32'd0);
        check("rst_wr_addr", {28'b0, rf_wr_addr}, 32'd0);
        check("rst_wr_data", {16'b0, rf_wr_data}, 32'd0);
        check("rst_done_err_busy", {29'b0, done, err, busy}, 32'd0);
        check("rst_op_count", {28'b0, op_count}, 32'd0);
        reset_n = 1'b1;
        tick();
        check("ready_after_rst", {31'b0, req_ready}, 32'd1);
        preload(4'd5, 16'hABCD);
        preload(4'd7, 16'h1111);

        // loadlit r3 <- sext(7F5)
        issue(2'b00, 4'd3, 11'h7F5);
        tick();
        req_valid = 1'b0;
        check("ll_ext_ctl", {30'b0, ext_controle}, 32'd0);
        check("ll_ext_const", {21'b0, ext_constante}, 32'h7F5);
        check("ll_rd_addr", {28'b0, rf_rd_addr}, 32'd3);
        check("ll_busy", {31'b0, busy}, 32'd1);
        check("ll_not_ready", {31'b0, req_ready}, 32'd0);
        tick();
        check("ll_merge_ctl", {30'b0, ext_controle}, 32'd3);
        tick();
        check("ll_done", {31'b0, done}, 32'd1);
        check("ll_wr_en", {31'b0, rf_wr_en}, 32'd1);
        tick();
        check("ll_count", {28'b0, op_count}, 32'd1);
        check("ll_ready", {31'b0, req_ready}, 32'd1);
        check("r3_value", {16'b0, rf[3]}, 32'h0000FFF5);

        // lcl then lch on r5 back to back
        run_legal(2'b01, 4'd5, 11'h012);
        check("r5_after_lcl", {16'b0, rf[5]}, 32'h0000AB12);
        run_legal(2'b10, 4'd5, 11'h034);
        check("r5_after_lch", {16'b0, rf[5]}, 32'h00003412);
        check("count_3", {28'b0, op_count}, 32'd3);

        // Illegal op
        issue(2'b11, 4'd2, 11'h155);
        tick();
        req_valid = 1'b0;
        check("ill_err", {31'b0, err}, 32'd1);
        check("ill_no_wr", {31'b0, rf_wr_en}, 32'd0);
        check("ill_ext_ctl", {30'b0, ext_controle}, 32'd3);
        check("ill_count", {28'b0, op_count}, 32'd3);
        tick();
        check("ill_ready", {31'b0, req_ready}, 32'd1);
        check("ill_err_low", {31'b0, err}, 32'd0);

        // Reset during MERGE aborts the write
        issue(2'b00, 4'd7, 11'h7F5);
        tick();
        req_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        sb_q.delete();
        gold[7] = 16'h1111;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_wr_en", {31'b0, rf_wr_en}, 32'd0);
        check("abort_count", {28'b0, op_count}, 32'd0);
        check("abort_ext_ctl", {30'b0, ext_controle}, 32'd3);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();
        tick();
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        check("r7_untouched", {16'b0, rf[7]}, 32'h00001111);

        // Saturation of op_count
        for (int i = 0; i < 16; i++) begin
            run_legal(2'b00, 4'd1, 11'h005);
            check("sat_count", {28'b0, op_count}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end

        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
